mem_stream_reader: RTL and testbench

Sequential read initiator for the data memory: given a base address and a word count, it walks the data memory's combinational read port one address per cycle and delivers the words in order on a valid/ready output stream. A small internal FIFO absorbs consumer backpressure. It sits between the data memory's read side (address out, read data in) and the NN datapath that consumes weights and activations as a stream.

---
 rtl/mem_stream_reader.sv | 126 ++++++++++++
 tb/tb_mem_stream_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Sequential read initiator: walks the data memory read port from baseAdd for
// wordCount words and streams them out through a small valid/ready FIFO.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; baseAdd/wordCount sampled here only
//   S_FETCH | one memory read per cycle, pushed into FIFO while room exists
//   S_DRAIN | all words fetched; waiting for the FIFO to empty
//   S_DONE  | single-cycle completion pulse, then back to idle

module mem_stream_reader #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 10,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  baseAdd,
   input  logic [COUNT_WIDTH-1:0] wordCount,
   output logic [ADDR_WIDTH-1:0]  memAdd,
   input  logic [DATA_WIDTH-1:0]  memReadData,
   output logic [DATA_WIDTH-1:0]  outData,
   output logic                   outValid,
   input  logic                   outReady,
   output logic                   busy,
   output logic                   done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

   logic [DATA_WIDTH-1:0]  fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       fifo_cnt_q;

   logic push;
   logic pop;

   // A pop at full frees the slot the same cycle, keeping 1 word/cycle throughput.
   assign pop  = (fifo_cnt_q != '0) && outReady;
   assign push = (state_q == S_FETCH) && ((fifo_cnt_q != DEPTH_C) || pop);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = baseAdd;
               remaining_d = wordCount;
               state_d     = (wordCount == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (push) begin
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - COUNT_WIDTH'(1);
               if (remaining_q == COUNT_WIDTH'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_mem_q[wr_ptr_q] <= memReadData;
   end

   assign memAdd   = addr_q;
   assign outValid = (fifo_cnt_q != '0);
   assign outData  = outValid ? fifo_mem_q[rd_ptr_q] : '0;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: basic burst, backpressure, zero count,
// start while busy, reset mid-burst and address wrap on a 4-bit instance.

module tb_mem_stream_reader;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [31:0] baseAdd;
   logic [9:0]  wordCount;
   logic [31:0] memAdd;
   logic [31:0] memReadData;
   logic [31:0] outData;
   logic        outValid;
   logic        outReady;
   logic        busy;
   logic        done;

   logic        start_w;
   logic [3:0]  base_w;
   logic [9:0]  count_w;
   logic [3:0]  memAdd_w;
   logic [31:0] rdata_w;
   logic [31:0] outData_w;
   logic        outValid_w;
   logic        ready_w;
   logic        busy_w;
   logic        done_w;

   logic [31:0] mem   [64];
   logic [31:0] mem_w [16];

   int n_tests = 0;
   int n_fail  = 0;

   mem_stream_reader dut (
      .CLK(CLK), .RST(RST), .start(start), .baseAdd(baseAdd), .wordCount(wordCount),
      .memAdd(memAdd), .memReadData(memReadData), .outData(outData), .outValid(outValid),
      .outReady(outReady), .busy(busy), .done(done)
   );

   mem_stream_reader #(.ADDR_WIDTH(4)) dut_w (
      .CLK(CLK), .RST(RST), .start(start_w), .baseAdd(base_w), .wordCount(count_w),
      .memAdd(memAdd_w), .memReadData(rdata_w), .outData(outData_w), .outValid(outValid_w),
      .outReady(ready_w), .busy(busy_w), .done(done_w)
   );

   assign memReadData = (memAdd < 32'd64) ? mem[memAdd[5:0]] : 32'hDEAD_BEEF;
   assign rdata_w     = mem_w[memAdd_w];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Start in the current cycle (cycle 0), then watch cycles 1..exp_done+2.
   // Expected words are memory[base+k] = 0x100+base+k.
   task automatic burst(input string name, input int base, input int n, input int stall,
                        input int exp_done, input int restart_cyc);
      int idx;
      start     = 1'b1;
      baseAdd   = 32'(base);
      wordCount = 10'(n);
      outReady  = 1'b0;
      tick();
      idx = 0;
      for (int c = 1; c <= exp_done + 2; c++) begin
         if (c == restart_cyc) begin
            start     = 1'b1;
            baseAdd   = 32'h30;
            wordCount = 10'd3;
         end else begin
            start = 1'b0;
         end
         outReady = (c > stall);
         if (c == 1) chk({name, "_addr_c1"}, 64'(memAdd), 64'(base));
         chk({name, "_busy"}, 64'(busy), 64'(c <= exp_done));
         chk({name, "_done"}, 64'(done), 64'(c == exp_done));
         if (c > exp_done) chk({name, "_valid_after"}, 64'(outValid), 64'(0));
         if (c >= 2 && c <= stall) begin
            chk({name, "_stall_valid"}, 64'(outValid), 64'(1));
            chk({name, "_stall_head"}, 64'(outData), 64'(32'h100 + 32'(base)));
         end
         if (c >= 5 && c <= stall) chk({name, "_stall_addr"}, 64'(memAdd), 64'(base + 4));
         if (outValid && outReady) begin
            chk({name, "_data"}, 64'(outData), 64'(32'h100 + 32'(base + idx)));
            idx++;
         end
         tick();
      end
      start = 1'b0;
      chk({name, "_nwords"}, 64'(idx), 64'(n));
   endtask

   int exp_a_w [4] = '{14, 15, 0, 1};
   int exp_d_w [4] = '{32'h20E, 32'h20F, 32'h200, 32'h201};

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
      for (int i = 0; i < 16; i++) mem_w[i] = 32'h200 + 32'(i);
      RST = 1'b1; start = 1'b0; baseAdd = '0; wordCount = '0; outReady = 1'b0;
      start_w = 1'b0; base_w = '0; count_w = '0; ready_w = 1'b0;
      tick();
      tick();
      chk("rst_memAdd", 64'(memAdd), 64'(0));
      chk("rst_outData", 64'(outData), 64'(0));
      chk("rst_outValid", 64'(outValid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_memAdd_w", 64'(memAdd_w), 64'(0));
      RST = 1'b0;
      tick();

      burst("basic", 8, 5, 0, 7, 0);
      burst("bp", 0, 10, 10, 21, 0);
      burst("zero", 5, 0, 0, 1, 0);
      burst("restart", 16, 6, 0, 8, 3);

      // Reset during cycle 4 of a stalled 10-word burst.
      start = 1'b1; baseAdd = 32'd0; wordCount = 10'd10; outReady = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("rstmid_done", 64'(done), 64'(0));
         if (c == 4) RST = 1'b1;
         tick();
      end
      chk("rstmid_valid", 64'(outValid), 64'(0));
      chk("rstmid_busy", 64'(busy), 64'(0));
      chk("rstmid_addr", 64'(memAdd), 64'(0));
      chk("rstmid_done_post", 64'(done), 64'(0));
      RST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rstmid_idle_done", 64'(done), 64'(0));
         chk("rstmid_idle_valid", 64'(outValid), 64'(0));
      end
      burst("after_rst", 8, 5, 0, 7, 0);

      // Address wrap on the 4-bit instance.
      start_w = 1'b1; base_w = 4'd14; count_w = 10'd4; ready_w = 1'b1;
      tick();
      start_w = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c <= 4) chk("wrap_addr", 64'(memAdd_w), 64'(exp_a_w[c-1]));
         if (c >= 2 && c <= 5) begin
            chk("wrap_valid", 64'(outValid_w), 64'(1));
            chk("wrap_data", 64'(outData_w), 64'(exp_d_w[c-2]));
         end
         chk("wrap_done", 64'(done_w), 64'(c == 6));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
